// File: rtl/product_accumulator.sv
// -----------------------------------------------------------------------------
// product_accumulator
//
// Sums a burst of unsigned product words (e.g. from an upstream 4x4 multiplier)
// and presents the finished sum on a valid/ready output port.
//
// A burst begins with a one-cycle start pulse while idle. len is sampled at
// that point and gives the number of products to accumulate (0 means
// 2^LEN_W). Products are accepted one per cycle while in_valid is high. After
// the last product is accepted, the sum is registered and offered on out_data
// until the consumer takes it.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both 1. in_ready and out_valid come only from the
// registered state, so they never depend combinationally on in_valid or
// out_ready. out_data and count stay stable while out_valid=1 and out_ready=0.
//
// Ports
//   clk          in   rising-edge clock for all state
//   rst_n        in   asynchronous active-low reset
//   start        in   begin a burst (honoured only in IDLE)
//   len          in   burst length, sampled on an accepted start; 0 = 2^LEN_W
//   clr          in   synchronous abort/clear; overrides everything else
//   in_valid     in   in_data carries a product
//   in_data      in   unsigned product word
//   in_ready     out  product accepted this cycle when in_valid=1
//   out_valid    out  out_data holds a finished burst sum
//   out_data     out  burst sum
//   out_ready    in   downstream accepts out_data
//   busy         out  burst in progress or result pending (ACCUM or DONE)
//   count        out  products accepted in the current burst
//   dbg_state_o  out  raw FSM state encoding for observation
// -----------------------------------------------------------------------------
module product_accumulator #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic [LEN_W:0]    count,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    // Target for len==0: the full 2^LEN_W beats, which needs the extra bit.
    localparam logic [LEN_W:0] FULL_BURST = {1'b1, {LEN_W{1'b0}}};
    localparam logic [LEN_W:0] COUNT_ONE  = {{LEN_W{1'b0}}, 1'b1};

    state_e            state_q,    state_d;
    logic [ACC_W-1:0]  acc_q,      acc_d;
    logic [LEN_W:0]    count_q,    count_d;
    logic [LEN_W:0]    target_q,   target_d;
    logic [ACC_W-1:0]  out_data_q, out_data_d;

    logic              beat;
    logic [ACC_W-1:0]  sum;
    logic [LEN_W:0]    count_inc;

    // A beat can only be taken in ACCUM, where in_ready is 1.
    assign beat      = (state_q == S_ACCUM) && in_valid;
    // Zero-extend the product; the width relation guarantees no wrap for any
    // legal burst, so no saturation logic is needed.
    assign sum       = acc_q + {{(ACC_W-DATA_W){1'b0}}, in_data};
    assign count_inc = count_q + COUNT_ONE;

    // -------------------------------------------------------------------------
    // Next-state and datapath update
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        target_d   = target_q;
        out_data_d = out_data_q;

        if (clr) begin
            // Abort from any state; also wins over a simultaneous start.
            state_d    = S_IDLE;
            acc_d      = '0;
            count_d    = '0;
            target_d   = '0;
            out_data_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d  = S_ACCUM;
                        acc_d    = '0;
                        count_d  = '0;
                        target_d = (len == '0) ? FULL_BURST : {1'b0, len};
                    end
                end

                S_ACCUM: begin
                    if (beat) begin
                        acc_d   = sum;
                        count_d = count_inc;
                        // Last beat: capture the final sum directly so the
                        // result is valid the cycle after this beat.
                        if (count_inc == target_q) begin
                            out_data_d = sum;
                            state_d    = S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            count_q    <= '0;
            target_q   <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            target_q   <= target_d;
            out_data_q <= out_data_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: all decoded from registered state only
    // -------------------------------------------------------------------------
    assign in_ready    = (state_q == S_ACCUM);
    assign out_valid   = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign out_data    = out_data_q;
    assign count       = count_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    localparam int LEN_W  = 8;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              clr;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [ACC_W-1:0]  out_data;
    logic              out_ready;
    logic              busy;
    logic [LEN_W:0]    count;
    logic [1:0]        dbg_state;

    int checks;
    int errors;

    product_accumulator #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W),
        .LEN_W (LEN_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .len        (len),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .busy       (busy),
        .count      (count),
        .dbg_state_o(dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    // Advance one cycle; inputs driven and outputs sampled 1 time unit after
    // the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd0);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_out_data"},  {16'd0, out_data},  32'd0);
        chk({tag, "_count"},     {23'd0, count},     32'd0);
        chk({tag, "_busy"},      {31'd0, busy},      32'd0);
    endtask

    task automatic idle_inputs();
        start     = 1'b0;
        len       = '0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
    endtask

    // Issue a start and move into ACCUM.
    task automatic do_start(input logic [LEN_W-1:0] l);
        start = 1'b1;
        len   = l;
        step();
        start = 1'b0;
        len   = '0;
    endtask

    task automatic beat(input logic [DATA_W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int exp_cnt;
        int cyc;

        checks = 0;
        errors = 0;

        // ---- reset with random inputs ----
        rst_n     = 1'b0;
        start     = 1'($urandom_range(0, 1));
        len       = LEN_W'($urandom_range(0, 255));
        clr       = 1'($urandom_range(0, 1));
        in_valid  = 1'($urandom_range(0, 1));
        in_data   = DATA_W'($urandom_range(0, 255));
        out_ready = 1'($urandom_range(0, 1));
        #2;
        chk_all_zero("rst_t2");
        for (int i = 0; i < 3; i++) begin
            start    = 1'b1;
            len      = LEN_W'($urandom_range(0, 255));
            in_valid = 1'($urandom_range(0, 1));
            in_data  = DATA_W'($urandom_range(0, 255));
            step();
        end
        chk_all_zero("rst_clocked");

        idle_inputs();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'($urandom_range(1, 255));
            step();
        end
        chk_all_zero("post_rst_idle");
        idle_inputs();

        // ---- basic burst: len=3, 225+100+1 = 326 ----
        do_start(8'd3);
        chk("basic_in_ready", {31'd0, in_ready}, 32'd1);
        chk("basic_busy",     {31'd0, busy},     32'd1);
        chk("basic_count0",   {23'd0, count},    32'd0);
        beat(8'd225);
        chk("basic_count1",   {23'd0, count},    32'd1);
        beat(8'd100);
        chk("basic_count2",   {23'd0, count},    32'd2);
        chk("basic_no_early_valid", {31'd0, out_valid}, 32'd0);
        beat(8'd1);
        chk("basic_out_valid", {31'd0, out_valid}, 32'd1);
        chk("basic_out_data",  {16'd0, out_data},  32'd326);
        chk("basic_count3",    {23'd0, count},     32'd3);
        chk("basic_in_ready_done", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("basic_release_valid", {31'd0, out_valid}, 32'd0);
        chk("basic_release_busy",  {31'd0, busy},      32'd0);

        // ---- max burst: len=0 -> 256 beats of 225 = 57600 ----
        do_start(8'd0);
        exp_cnt = 0;
        cyc     = 0;
        while (exp_cnt < 256 && cyc < 3000) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_data  = 8'd225;
            step();
            cyc++;
            if (in_valid) begin
                exp_cnt++;
                if (exp_cnt == 128) chk("max_count_mid", {23'd0, count}, 32'd128);
                if (exp_cnt == 255) chk("max_no_early_valid", {31'd0, out_valid}, 32'd0);
            end
        end
        in_valid = 1'b0;
        in_data  = '0;
        chk("max_beats_within_budget", exp_cnt, 32'd256);
        chk("max_out_valid", {31'd0, out_valid}, 32'd1);
        chk("max_out_data",  {16'd0, out_data},  32'hE100);
        chk("max_count",     {23'd0, count},     32'd256);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("max_release_valid", {31'd0, out_valid}, 32'd0);

        // ---- backpressure: len=2, 10+20 = 30 held while out_ready=0 ----
        do_start(8'd2);
        beat(8'd10);
        beat(8'd20);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_out_data",  {16'd0, out_data},  32'd30);
            chk("bp_in_ready",  {31'd0, in_ready},  32'd0);
            chk("bp_count",     {23'd0, count},     32'd2);
            if (i == 2) begin
                start = 1'b1;
                len   = 8'd5;
            end
            step();
            start = 1'b0;
            len   = '0;
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_release_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_release_busy",  {31'd0, busy},      32'd0);
        step();
        chk("bp_start_ignored", {31'd0, busy}, 32'd0);

        // ---- abort: clr together with start wins ----
        do_start(8'd4);
        beat(8'd5);
        beat(8'd6);
        chk("abort_count_before", {23'd0, count}, 32'd2);
        clr   = 1'b1;
        start = 1'b1;
        len   = 8'd9;
        step();
        clr   = 1'b0;
        start = 1'b0;
        len   = '0;
        chk_all_zero("abort");
        step();
        chk("abort_still_idle", {31'd0, busy}, 32'd0);
        do_start(8'd1);
        beat(8'd7);
        chk("abort_next_valid", {31'd0, out_valid}, 32'd1);
        chk("abort_next_data",  {16'd0, out_data},  32'd7);
        chk("abort_next_count", {23'd0, count},     32'd1);

        // ---- clr while DONE drops result with no further valid ----
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk_all_zero("clr_done");

        // ---- reset mid-ACCUM ----
        do_start(8'd5);
        beat(8'd40);
        beat(8'd50);
        chk("midrst_count_before", {23'd0, count}, 32'd2);
        in_valid = 1'b1;
        in_data  = 8'd60;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst_async");
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("midrst_no_valid", {31'd0, out_valid}, 32'd0);
            chk("midrst_no_busy",  {31'd0, busy},      32'd0);
        end
        idle_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
